cpm_axis_credit_rx_bridge: RTL
==============================

CPM_AXIS_CREDIT_RX_BRIDGE -- requirements
Module: cpm_axis_credit_rx_bridge

Interface
REQ-001 Parameter DATA_W, default 512: tdata width in bits.
REQ-002 Parameter USER_W, default 161: tuser width in bits (229 for the CQ instance).
REQ-003 Parameter KEEP_W, default DATA_W/32: tkeep width, one bit per dword.
REQ-004 Parameter DEPTH, default 16: buffer depth in beats; power of 2, range 4..64.
REQ-005 Parameter CW, default clog2(DEPTH+1): width of the count outputs.
REQ-006 user_clk  in  1  sole clock; all logic is on the rising edge.
REQ-007 user_reset_n  in  1  asynchronous, active-low reset.
REQ-008 s_tdata/s_tuser/s_tlast/s_tkeep  in  DATA_W/USER_W/1/KEEP_W  credit-side beat payload.
REQ-009 s_tvalid  in  1  beat present; no ready is involved.
REQ-010 s_credit  out  1  one-cycle pulse that grants one beat of buffer space to the source.
REQ-011 m_tdata/m_tuser/m_tlast/m_tkeep  out  DATA_W/USER_W/1/KEEP_W  valid/ready-side payload.
REQ-012 m_tvalid  out  1 and m_tready  in  1  standard AXIS handshake.
REQ-013 credit_en  in  1  when low, no new credits are issued.
REQ-014 fifo_level  out  CW  number of beats currently buffered.
REQ-015 credit_outstanding  out  CW  number of credits issued but not yet consumed.
REQ-016 overflow_err  out  1  sticky flag: a beat arrived with no outstanding credit.

Function
REQ-017 A beat is accepted on any cycle with s_tvalid=1 and credit_outstanding>0.
- An accepted beat is written to the FIFO.
- credit_outstanding decrements by 1.
REQ-018 A beat arriving with credit_outstanding=0:
- is dropped;
- sets overflow_err from the next cycle until reset.
REQ-019 Credit issue rule: s_credit=1 in the cycle after an edge where all hold:
- credit_en=1;
- fifo_level + credit_outstanding + s_credit < DEPTH.
REQ-020 At most one credit is issued per cycle; each pulse increments credit_outstanding by 1.
REQ-021 Invariant at every edge: fifo_level + credit_outstanding <= DEPTH.
REQ-022 Buffer is first-word-fall-through.
- A beat accepted at edge N appears on m_* with m_tvalid=1 after edge N (latency 1 cycle).
- An empty FIFO does not pass data through combinationally.
REQ-023 A pop occurs on m_tvalid & m_tready; fifo_level decrements; the next beat is presented in the same cycle following that edge.
REQ-024 m_* payload is held stable while m_tvalid=1 and m_tready=0.
REQ-025 Simultaneous push and pop: fifo_level is unchanged; this is legal at full and at empty (at empty the push lands and m_tvalid rises).
REQ-026 Simultaneous credit issue and beat acceptance: credit_outstanding is unchanged.
REQ-027 Deasserting credit_en stops new pulses from the next cycle; beats against already-issued credits are still accepted.
REQ-028 FIFO pointers are log2(DEPTH) bits with natural wrap-around; full/empty are derived from the level counter.
REQ-029 Beats are forwarded unmodified; tlast and tkeep are not inspected.

Reset
REQ-030 Assertion of user_reset_n=0 immediately clears, asynchronously:
- s_credit, m_tvalid, fifo_level, credit_outstanding, overflow_err = 0;
- m_tdata/m_tuser/m_tkeep/m_tlast = 0.
REQ-031 Reset mid-packet discards all buffered beats and all outstanding credits; no partial packet is emitted afterwards.
REQ-032 After release with credit_en=1, DEPTH credit pulses are issued on consecutive cycles, the first on the second edge after release.

Structure
REQ-033 Package cpm_axis_bridge_pkg holds:
- constants CPM_AXIS_DATA_W=512, CPM_RC_USER_W=161, CPM_CQ_USER_W=229;
- a packed beat struct typedef per data/user width.
REQ-034 Sub-module cpm_axis_sync_fifo (FWFT, parametrised width/depth) holds the storage; the credit accounting stays in the top module.

Verification
REQ-035 Post-reset, credit_en=1, no traffic -> 16 consecutive s_credit pulses, then none; credit_outstanding=16.
REQ-036 16 beats at s_tvalid=1 with m_tready=0 -> fifo_level=16, credit_outstanding=0, no further pulses.
- Raise m_tready for one cycle -> exactly one new pulse.
REQ-037 Extra beat sent with credit_outstanding=0 -> beat is absent on m_*, overflow_err=1 and stays 1.
REQ-038 Streaming at full rate with m_tready=1 -> level stays at 1, m_* matches input order, and credits sustain 1 beat/cycle.
REQ-039 Reset asserted with 5 beats buffered and 3 credits outstanding -> all outputs 0 at once; the release sequence matches REQ-035.
REQ-040 credit_en dropped after 4 pulses -> exactly 4 beats are accepted and no further pulses occur until credit_en returns to 1.

Source files
------------

// File: rtl/cpm_axis_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpm_axis_bridge_pkg
//  Description : Shared constants and beat typedefs for the CPM AXI-Stream
//                credit/ready bridges (RC and CQ flavours).
//  Contents    : CPM_AXIS_DATA_W, CPM_RC_USER_W, CPM_CQ_USER_W,
//                CPM_AXIS_KEEP_W, cpm_rc_beat_t, cpm_cq_beat_t
//  Revision    : 1.0 - initial release
// ============================================================================
package cpm_axis_bridge_pkg;

  localparam int CPM_AXIS_DATA_W = 512;
  localparam int CPM_RC_USER_W   = 161;
  localparam int CPM_CQ_USER_W   = 229;
  localparam int CPM_AXIS_KEEP_W = CPM_AXIS_DATA_W / 32;

  // One beat as stored in the bridge buffer, last field in the MSBs.
  typedef struct packed {
    logic                       tlast;
    logic [CPM_AXIS_KEEP_W-1:0] tkeep;
    logic [CPM_RC_USER_W-1:0]   tuser;
    logic [CPM_AXIS_DATA_W-1:0] tdata;
  } cpm_rc_beat_t;

  typedef struct packed {
    logic                       tlast;
    logic [CPM_AXIS_KEEP_W-1:0] tkeep;
    logic [CPM_CQ_USER_W-1:0]   tuser;
    logic [CPM_AXIS_DATA_W-1:0] tdata;
  } cpm_cq_beat_t;

endpackage
`default_nettype wire

// File: rtl/cpm_axis_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : cpm_axis_sync_fifo
//  Description : First-word-fall-through synchronous FIFO. The head entry is
//                presented on o_data whenever o_valid is high; an empty FIFO
//                drives zeros and never bypasses i_data combinationally.
//  Ports       : clk, rst_n (async, active-low)
//                i_push/i_data  - write side
//                i_pop          - consume head (ignored when empty)
//                o_data/o_valid - head entry / not empty
//                o_level        - number of stored entries
//  Revision    : 1.0 - initial release
// ============================================================================
module cpm_axis_sync_fifo
  import cpm_axis_bridge_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic [LVL_W-1:0] o_level
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] C_DEPTH = LVL_W'(DEPTH);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0]  r_level;

  logic w_empty;
  logic w_full;
  logic w_do_push;
  logic w_do_pop;

  assign w_empty   = (r_level == '0);
  assign w_full    = (r_level == C_DEPTH);
  assign w_do_pop  = i_pop && !w_empty;
  // A pop in the same cycle frees the slot, so a push at full is still legal.
  assign w_do_push = i_push && (!w_full || w_do_pop);

  // Storage carries no reset; the output mux below hides stale contents.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_valid = !w_empty;
  assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_level = r_level;

endmodule
`default_nettype wire

// File: rtl/cpm_axis_credit_rx_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : cpm_axis_credit_rx_bridge
//  Description : Converts a credit-based beat stream into AXI-Stream
//                valid/ready. Credits are issued one per cycle while buffer
//                space (level + outstanding + in-flight pulse) remains.
//  Ports       : user_clk, user_reset_n (async, active-low)
//                s_tdata/s_tuser/s_tkeep/s_tlast/s_tvalid - credit-side beat
//                s_credit      - one-beat credit grant pulse
//                m_tdata/m_tuser/m_tkeep/m_tlast/m_tvalid/m_tready - AXIS out
//                credit_en     - gate for new credit pulses
//                fifo_level, credit_outstanding - occupancy counters
//                overflow_err  - sticky: beat arrived without a credit
//  Revision    : 1.0 - initial release
// ============================================================================
module cpm_axis_credit_rx_bridge
  import cpm_axis_bridge_pkg::*;
#(
  parameter int DATA_W = CPM_AXIS_DATA_W,
  parameter int USER_W = CPM_RC_USER_W,
  parameter int KEEP_W = DATA_W / 32,
  parameter int DEPTH  = 16,
  parameter int CW     = $clog2(DEPTH + 1)
) (
  input  logic              user_clk,
  input  logic              user_reset_n,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic [USER_W-1:0] s_tuser,
  input  logic              s_tlast,
  input  logic [KEEP_W-1:0] s_tkeep,
  input  logic              s_tvalid,
  output logic              s_credit,
  output logic [DATA_W-1:0] m_tdata,
  output logic [USER_W-1:0] m_tuser,
  output logic              m_tlast,
  output logic [KEEP_W-1:0] m_tkeep,
  output logic              m_tvalid,
  input  logic              m_tready,
  input  logic              credit_en,
  output logic [CW-1:0]     fifo_level,
  output logic [CW-1:0]     credit_outstanding,
  output logic              overflow_err
);

  localparam int BEAT_W = DATA_W + USER_W + KEEP_W + 1;
  localparam logic [CW:0] C_DEPTH = (CW + 1)'(DEPTH);

  logic              r_armed;
  logic              r_s_credit;
  logic [CW-1:0]     r_credit_outstanding;
  logic              r_overflow_err;

  logic              w_accept;
  logic              w_issue;
  logic [CW:0]       w_space_used;
  logic [BEAT_W-1:0] w_wr_beat;
  logic [BEAT_W-1:0] w_rd_beat;
  logic [CW-1:0]     w_fifo_level;

  assign w_accept = s_tvalid && (r_credit_outstanding != '0);

  // The pulse currently on s_credit is not yet counted as outstanding, so it
  // is added here to keep the total grant within the buffer depth.
  assign w_space_used = {1'b0, w_fifo_level} + {1'b0, r_credit_outstanding}
                      + (CW + 1)'(r_s_credit);
  // r_armed holds off the first grant by one edge after reset release.
  assign w_issue = r_armed && credit_en && (w_space_used < C_DEPTH);

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      r_armed              <= 1'b0;
      r_s_credit           <= 1'b0;
      r_credit_outstanding <= '0;
      r_overflow_err       <= 1'b0;
    end else begin
      r_armed    <= 1'b1;
      r_s_credit <= w_issue;
      case ({r_s_credit, w_accept})
        2'b10:   r_credit_outstanding <= r_credit_outstanding + CW'(1);
        2'b01:   r_credit_outstanding <= r_credit_outstanding - CW'(1);
        default: r_credit_outstanding <= r_credit_outstanding;
      endcase
      if (s_tvalid && !w_accept) r_overflow_err <= 1'b1;
    end
  end

  assign w_wr_beat = {s_tlast, s_tkeep, s_tuser, s_tdata};

  cpm_axis_sync_fifo #(
    .WIDTH (BEAT_W),
    .DEPTH (DEPTH),
    .LVL_W (CW)
  ) u_fifo (
    .clk     (user_clk),
    .rst_n   (user_reset_n),
    .i_push  (w_accept),
    .i_data  (w_wr_beat),
    .i_pop   (m_tready),
    .o_data  (w_rd_beat),
    .o_valid (m_tvalid),
    .o_level (w_fifo_level)
  );

  assign {m_tlast, m_tkeep, m_tuser, m_tdata} = w_rd_beat;

  assign s_credit           = r_s_credit;
  assign fifo_level         = w_fifo_level;
  assign credit_outstanding = r_credit_outstanding;
  assign overflow_err       = r_overflow_err;

endmodule
`default_nettype wire
